// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and 8N1 frame constants,
// kept here so a future transmitter can use the same framing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_STOP_BITS  = 1;
    localparam int   UART_DIV        = 16;
    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage and no fall-through bypass.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to overwrite.
    assign do_push = push && (!full || do_pop);
    assign data    = mem[rptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_sink.sv
// 8N1 UART receiver feeding a small byte FIFO with a valid/ready output port.
// Reports bad stop bits and bytes lost to a full FIFO as single-cycle pulses.
module uart_rx_sink
    import uart_pkg::*;
#(
    parameter int DIV        = UART_DIV,
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(DIV);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 sync1;
    logic                 rx_s;
    rx_state_e            state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;

    logic fifo_full;
    logic fifo_empty;
    logic stop_sample;
    logic push_req;
    logic pop;

    assign stop_sample = (state == STOP) && (cnt == BIT_LAST);
    assign push_req    = stop_sample && (rx_s == UART_STOP_BIT);
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= UART_IDLE_LEVEL;
            rx_s  <= UART_IDLE_LEVEL;
        end else begin
            sync1 <= rxd;
            rx_s  <= sync1;
        end
    end

    // Counters restart on every state change, so each one measures from the
    // start of its own bit and never runs past DIV-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_s == UART_START_BIT) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= (rx_s == UART_START_BIT) ? DATA : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s == UART_STOP_BIT) begin
                            state   <= IDLE;
                            overrun <= fifo_full && !pop;
                        end else begin
                            state     <= BREAK;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s == UART_IDLE_LEVEL) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (shift),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .data      (out_data)
    );

endmodule

// File: tb/tb_uart_rx_sink.sv
// Directed bench for uart_rx_sink: a table of single frames plus hand-written
// sequences for back-pressure, glitches, line breaks, overrun and reset.
module tb_uart_rx_sink;

    localparam int DIV = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       frame_err;
    logic       overrun;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] got_q[$];
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int both_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_beats;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    vec_t vecs[6];

    uart_rx_sink #(
        .DIV        (DIV),
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rxd       (rxd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    // Record every accepted beat and every error pulse away from the rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (frame_err && overrun) both_cnt <= both_cnt + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic hold_bit(input logic b, input int cycles);
        rxd = b;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic idle(input int cycles);
        hold_bit(1'b1, cycles);
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic stop_bit, input int stop_len);
        hold_bit(1'b0, DIV);
        for (int i = 0; i < 8; i++) begin
            hold_bit(d[i], DIV);
        end
        hold_bit(stop_bit, stop_len);
        rxd = 1'b1;
    endtask

    initial begin
        int base;
        int f0;
        int o0;

        vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 0, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0, 0};
        vecs[3] = '{8'h81, 1'b1, 1, 8'h81, 0, 0};
        vecs[4] = '{8'h3C, 1'b0, 0, 8'h00, 1, 0};
        vecs[5] = '{8'hA5, 1'b1, 1, 8'hA5, 0, 0};

        #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset out_data", 32'(out_data), 32'd0);
        check_output("reset frame_err", 32'(frame_err), 32'd0);
        check_output("reset overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        idle(10);

        // Single frames with the consumer always ready
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            base = got_q.size();
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            apply_stimulus(vecs[v].data, vecs[v].stop_bit, DIV);
            idle(24);
            check_output($sformatf("vec%0d beats", v), 32'(got_q.size() - base), 32'(vecs[v].exp_beats));
            if (vecs[v].exp_beats > 0 && got_q.size() > base)
                check_output($sformatf("vec%0d data", v), 32'(got_q[base]), 32'(vecs[v].exp_data));
            check_output($sformatf("vec%0d frame_err", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
            check_output($sformatf("vec%0d overrun", v), 32'(ovr_cnt - o0), 32'(vecs[v].exp_ovr));
            check_output($sformatf("vec%0d valid after", v), 32'(out_valid), 32'd0);
        end

        // Back-to-back frames buffered, then drained on two ready cycles
        out_ready = 1'b0;
        base = got_q.size();
        apply_stimulus(8'hA5, 1'b1, DIV);
        apply_stimulus(8'h3C, 1'b1, DIV);
        idle(24);
        check_output("b2b valid", 32'(out_valid), 32'd1);
        check_output("b2b head", 32'(out_data), 32'hA5);
        idle(5);
        check_output("b2b head stable", 32'(out_data), 32'hA5);
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 out_ready = 1'b0;
        check_output("b2b valid after drain", 32'(out_valid), 32'd0);
        check_output("b2b beats", 32'(got_q.size() - base), 32'd2);
        if (got_q.size() >= base + 2) begin
            check_output("b2b first", 32'(got_q[base]), 32'hA5);
            check_output("b2b second", 32'(got_q[base + 1]), 32'h3C);
        end

        // Short low glitch must be rejected silently
        out_ready = 1'b1;
        base = got_q.size();
        f0 = ferr_cnt;
        hold_bit(1'b0, 3);
        idle(200);
        check_output("glitch valid", 32'(out_valid), 32'd0);
        check_output("glitch beats", 32'(got_q.size() - base), 32'd0);
        check_output("glitch frame_err", 32'(ferr_cnt - f0), 32'd0);

        // Bad stop bit with the line held low, then a clean frame
        base = got_q.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        apply_stimulus(8'h7E, 1'b0, DIV + 40);
        idle(30);
        check_output("break frame_err", 32'(ferr_cnt - f0), 32'd1);
        check_output("break beats", 32'(got_q.size() - base), 32'd0);
        check_output("break overrun", 32'(ovr_cnt - o0), 32'd0);
        apply_stimulus(8'h11, 1'b1, DIV);
        idle(24);
        check_output("after break beats", 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base)
            check_output("after break data", 32'(got_q[base]), 32'h11);
        check_output("after break frame_err", 32'(ferr_cnt - f0), 32'd1);

        // Five frames into a four-entry FIFO with no consumer
        out_ready = 1'b0;
        base = got_q.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        for (int b = 1; b <= 5; b++) begin
            apply_stimulus(8'(b), 1'b1, DIV);
        end
        idle(24);
        check_output("overrun count", 32'(ovr_cnt - o0), 32'd1);
        check_output("overrun frame_err", 32'(ferr_cnt - f0), 32'd0);
        check_output("full head", 32'(out_data), 32'h01);
        // Stop bit is sampled 155 rising edges after the start bit is driven
        fork
            apply_stimulus(8'h06, 1'b1, DIV);
            begin
                repeat (154) @(posedge clock);
                #1 out_ready = 1'b1;
                @(posedge clock);
                #1 out_ready = 1'b0;
            end
        join
        idle(24);
        check_output("push+pop on full overrun", 32'(ovr_cnt - o0), 32'd1);
        check_output("push+pop on full popped", 32'(got_q.size() - base), 32'd1);
        out_ready = 1'b1;
        idle(10);
        check_output("full drain beats", 32'(got_q.size() - base), 32'd5);
        if (got_q.size() >= base + 5) begin
            for (int k = 0; k < 5; k++) begin
                check_output($sformatf("full drain %0d", k), 32'(got_q[base + k]),
                             (k < 4) ? 32'(k + 1) : 32'h06);
            end
        end
        check_output("full drain valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a frame with a byte already buffered
        out_ready = 1'b0;
        apply_stimulus(8'h99, 1'b1, DIV);
        idle(24);
        check_output("pre-reset valid", 32'(out_valid), 32'd1);
        check_output("pre-reset data", 32'(out_data), 32'h99);
        fork
            apply_stimulus(8'hC3, 1'b1, DIV);
            begin
                repeat (60) @(posedge clock);
                #3 reset = 1'b1;
                #1;
                check_output("mid-frame reset valid", 32'(out_valid), 32'd0);
                check_output("mid-frame reset data", 32'(out_data), 32'd0);
                check_output("mid-frame reset frame_err", 32'(frame_err), 32'd0);
                check_output("mid-frame reset overrun", 32'(overrun), 32'd0);
            end
        join
        idle(5);
        reset = 1'b0;
        idle(10);
        out_ready = 1'b1;
        base = got_q.size();
        f0 = ferr_cnt;
        apply_stimulus(8'h5A, 1'b1, DIV);
        idle(24);
        check_output("post-reset beats", 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base)
            check_output("post-reset data", 32'(got_q[base]), 32'h5A);
        check_output("post-reset frame_err", 32'(ferr_cnt - f0), 32'd0);

        check_output("frame_err and overrun together", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
